multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Brief    : Moore control unit for a multicycle RV32-style datapath.
//             It sequences fetch, decode, address, memory, execute and
//             write-back steps, and drives every datapath select and enable.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic       illegal_op_o,
  output logic       instr_done_o,
  output logic [3:0] state_o
);

  // --------------------------------------------------------------------------
  // State encodings (the debug port exposes these values directly)
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRWB   = 4'd12;

  // --------------------------------------------------------------------------
  // Opcodes recognised by the decoder
  // --------------------------------------------------------------------------
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // --------------------------------------------------------------------------
  // Datapath select encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       w_branch_taken;
  logic       w_unused;

  // Only funct3[0] distinguishes beq/bne; the upper bits are intentionally ignored.
  assign w_unused = &{1'b0, funct3_i[2:1]};

  // Bit 0 clear selects "branch if equal", set selects "branch if not equal".
  assign w_branch_taken = (~funct3_i[0] & zero_i) | (funct3_i[0] & ~zero_i);

  // State register; reset forces FETCH so any in-flight instruction is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states stall until the handshake completes.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        case (op_i)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
      end
      S_JAL: begin
        state_d = S_ALUWB;
      end
      S_JALR: begin
        state_d = S_JALRWB;
      end
      S_JALRWB: begin
        state_d = S_FETCH;
      end
      default: begin
        // Unused codes 13-15 recover to FETCH.
        state_d = S_FETCH;
      end
    endcase
  end

  // Output decode per state; strobes are masked while reset is held so the
  // FETCH encoding seen during reset never issues a memory read.
  always_comb begin
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    result_src_o = RES_ALUOUT;
    illegal_op_o = 1'b0;
    instr_done_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o   = 1'b1;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALU;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
        case (op_i)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BRANCH, OP_JAL, OP_JALR: illegal_op_o = 1'b0;
          default:                    illegal_op_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        mem_read_o   = 1'b1;
        adr_src_o    = 1'b1;
        result_src_o = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src_o = RES_MEM;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_o  = 1'b1;
        adr_src_o    = 1'b1;
        result_src_o = RES_ALUOUT;
        instr_done_o = mem_ready_i;
      end
      S_EXECR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_FUNC;
      end
      S_EXECI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        result_src_o = RES_ALUOUT;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALUOP_SUB;
        result_src_o = RES_ALUOUT;
        pc_write_o   = w_branch_taken;
        instr_done_o = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o  = SRCA_OLDPC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALUOUT;
        pc_write_o   = 1'b1;
      end
      S_JALR: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_IMM;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALU;
        pc_write_o   = 1'b1;
      end
      S_JALRWB: begin
        alu_src_a_o  = SRCA_OLDPC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALU;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      default: begin
        mem_read_o = 1'b0;
      end
    endcase
    if (!rst_n) begin
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      illegal_op_o = 1'b0;
      instr_done_o = 1'b0;
    end
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    case (op_i)
      OP_STORE:  imm_src_o = IMM_S;
      OP_BRANCH: imm_src_o = IMM_B;
      OP_JAL:    imm_src_o = IMM_J;
      default:   imm_src_o = IMM_I;
    endcase
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Brief    : Directed self-checking bench for multicycle_control_fsm.
//             Expected output vectors are queued as each cycle is driven and
//             compared on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t exp_q[$];

  multicycle_control_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_i         (op),
    .funct3_i     (funct3),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .result_src_o (result_src),
    .imm_src_o    (imm_src),
    .illegal_op_o (illegal_op),
    .instr_done_o (instr_done),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: state, 6 strobes, a, b, alu_op, result_src, imm_src, illegal, done
  wire [21:0] obs = {state, mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, result_src, imm_src,
                     illegal_op, instr_done};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: imm_of = 2'b01;
      7'b1100011: imm_of = 2'b10;
      7'b1101111: imm_of = 2'b11;
      default:    imm_of = 2'b00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one expected vector per clock while out of reset.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, obs, e.v);
    end
  end

  // Drive one cycle (called at posedge+1) and queue its expected outputs.
  // sb = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write}
  task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [5:0] sb, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] alu, input logic [1:0] res,
                     input logic ill, input logic done);
    exp_t e;
    op = o; funct3 = f3; zero = z; mem_ready = mr;
    e.tag = tag;
    e.v   = {st, sb, a, b, alu, res, imm_of(o), ill, done};
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] JLR  = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  initial begin
    rst_n = 1'b0; op = LW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    // State 0, strobes 0 while reset held; FETCH selects still visible.
    check("reset_hold", obs, {4'd0, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw, mem_ready=1: 0,1,2,3,4
    cyc("lw_fetch",   LW, 3'b010, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("lw_decode",  LW, 3'b010, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("lw_memadr",  LW, 3'b010, 0, 1, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("lw_memread", LW, 3'b010, 0, 1, 4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("lw_memwb",   LW, 3'b010, 0, 1, 4'd4, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1);

    // sw with fetch wait of 2 cycles and 3 MEMWRITE wait cycles
    cyc("sw_fetch_w0", SW, 3'b010, 0, 0, 4'd0, 6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("sw_fetch_w1", SW, 3'b010, 0, 0, 4'd0, 6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("sw_fetch",    SW, 3'b010, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("sw_decode",   SW, 3'b010, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("sw_memadr",   SW, 3'b010, 0, 1, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("sw_memwr_w0", SW, 3'b010, 0, 0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("sw_memwr_w1", SW, 3'b010, 0, 0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("sw_memwr_w2", SW, 3'b010, 0, 0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("sw_memwr",    SW, 3'b010, 0, 1, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    // R-type
    cyc("r_fetch",  RT, 3'b000, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("r_decode", RT, 3'b000, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("r_exec",   RT, 3'b000, 0, 1, 4'd6, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc("r_aluwb",  RT, 3'b000, 0, 1, 4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    // I-type
    cyc("i_fetch",  IT, 3'b000, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("i_decode", IT, 3'b000, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("i_exec",   IT, 3'b000, 0, 1, 4'd7, 6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
    cyc("i_aluwb",  IT, 3'b000, 0, 1, 4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    // beq taken (zero=1)
    cyc("beq_fetch",  BR, 3'b000, 1, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("beq_decode", BR, 3'b000, 1, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("beq_branch", BR, 3'b000, 1, 1, 4'd9, 6'b000010, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1);
    // bne with zero=1: not taken
    cyc("bne_fetch",  BR, 3'b001, 1, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("bne_decode", BR, 3'b001, 1, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("bne_nt",     BR, 3'b001, 1, 1, 4'd9, 6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1);
    // bne with zero=0: taken
    cyc("bne2_fetch",  BR, 3'b001, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("bne2_decode", BR, 3'b001, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("bne_t",       BR, 3'b001, 0, 1, 4'd9, 6'b000010, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1);
    // beq with zero=0: not taken
    cyc("beq2_fetch",  BR, 3'b000, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("beq2_decode", BR, 3'b000, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("beq_nt",      BR, 3'b000, 0, 1, 4'd9, 6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1);

    // jal
    cyc("jal_fetch",  JL, 3'b000, 0, 1, 4'd0,  6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("jal_decode", JL, 3'b000, 0, 1, 4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("jal_jal",    JL, 3'b000, 0, 1, 4'd10, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
    cyc("jal_aluwb",  JL, 3'b000, 0, 1, 4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    // jalr
    cyc("jalr_fetch",  JLR, 3'b000, 0, 1, 4'd0,  6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("jalr_decode", JLR, 3'b000, 0, 1, 4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("jalr_jalr",   JLR, 3'b000, 0, 1, 4'd11, 6'b000010, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0);
    cyc("jalr_wb",     JLR, 3'b000, 0, 1, 4'd12, 6'b000001, 2'b01, 2'b10, 2'b00, 2'b10, 0, 1);

    // illegal opcode (lui is not supported)
    cyc("ill_fetch",  LUI, 3'b000, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("ill_decode", LUI, 3'b000, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0);
    cyc("ill_after",  LUI, 3'b000, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);

    // lw aborted by reset while MEMREAD waits on mem_ready
    cyc("rst_decode",  LW, 3'b010, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("rst_memadr",  LW, 3'b010, 0, 1, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc("rst_memrd_w", LW, 3'b010, 0, 0, 4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", obs, {4'd0, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("rst_fetch",  LW, 3'b010, 0, 1, 4'd0, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("rst_decode2", LW, 3'b010, 0, 1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);

    @(negedge clk); #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
